arbitro_memoria_vga: RTL

- Shares one single-port synchronous image RAM between two requesters: the VGA scan-out address path (`contador_direccion` output, 18-bit) and the CPU/processor data port.
- Sits between those requesters and the RAM, in front of the `data_dram` input of the VGA controller.
- Request/ack handshakes, pipelined at one access per cycle.
- Priority is blanking-aware, with a CPU starvation guard.

---
 rtl/arbitro_memoria_vga_pkg.sv | 19 +
 rtl/arbitro_memoria_vga_if.sv | 36 +++
 rtl/arbitro_memoria_vga_linea_retardo_tag.sv | 29 ++
 rtl/arbitro_memoria_vga.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/arbitro_memoria_vga_pkg.sv
// Shared types and default widths for the VGA/CPU image-RAM arbiter.
package vga_arb_pkg;

    localparam int DEF_ADDR_W = 18;
    localparam int DEF_DATA_W = 8;

    // Which requester a read in flight belongs to.
    typedef enum logic {
        OWN_VGA = 1'b0,
        OWN_CPU = 1'b1
    } owner_t;

    // One stage of the read-return tag pipeline.
    typedef struct packed {
        logic   valid;
        owner_t owner;
    } rd_tag_t;

endpackage

// File: rtl/arbitro_memoria_vga_if.sv
// Request/ack and RAM bus bundle between the requesters, the arbiter and the RAM.
// The slave modport is the arbiter's view; master is the environment's view.
interface arbitro_memoria_vga_if #(
    parameter int ADDR_W = vga_arb_pkg::DEF_ADDR_W,
    parameter int DATA_W = vga_arb_pkg::DEF_DATA_W
);
    logic              n_blank;
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_ack;
    logic [DATA_W-1:0] vga_rdata;
    logic              vga_rvalid;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  n_blank, vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        output vga_ack, vga_rdata, vga_rvalid, cpu_ack, cpu_rdata, cpu_rvalid,
               mem_addr, mem_we, mem_wdata
    );

    modport master (
        output n_blank, vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        input  vga_ack, vga_rdata, vga_rvalid, cpu_ack, cpu_rdata, cpu_rvalid,
               mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/arbitro_memoria_vga_linea_retardo_tag.sv
// Fixed-depth delay line of read tags; tells the return stage who owns the
// RAM data arriving this cycle.
module linea_retardo_tag
    import vga_arb_pkg::*;
#(
    parameter int DEPTH = 2
)(
    input  logic    clock_25,
    input  logic    reset,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);
    rd_tag_t etapa [DEPTH];

    // Shift tags one stage per clock; reset empties every stage.
    // NOTE: sequential state uses non-blocking (<=) so every stage samples the old value of its neighbour.
    // NOTE: unlike a data RAM, every stage is reset: a stale valid bit would emit a phantom rvalid.
    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) etapa[i] <= '0;
        end else begin
            etapa[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) etapa[i] <= etapa[i-1];
        end
    end

    assign tag_out = etapa[DEPTH-1];

endmodule

// File: rtl/arbitro_memoria_vga.sv
// Arbiter sharing one single-port image RAM between VGA scan-out and the CPU.
// VGA wins during active video, CPU wins during blanking, and a CPU that has
// been denied STARVE_LIMIT cycles in a row is forced through.
// Optional build macro ARB_STATS_EN adds stat_conflict / stat_forced counters.
module arbitro_memoria_vga
    import vga_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int RD_LAT       = 1,
    parameter int STARVE_LIMIT = 8
)(
    input  logic                  clock_25,
    input  logic                  reset,
    arbitro_memoria_vga_if.slave  bus
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]           stat_conflict,
    output logic [15:0]           stat_forced
`endif
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic              vga_grant;
    logic              cpu_grant;
    logic              forced_grant;
    logic              starved;
    logic [CNT_W-1:0]  starve_cnt;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_we_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] vga_rdata_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic              vga_rvalid_q;
    logic              cpu_rvalid_q;
    rd_tag_t           tag_in;
    rd_tag_t           tag_out;

    assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT));

    // Combinational grant: starvation guard first, then blanking-aware priority.
    // NOTE: every output of this block is given a default first so no path leaves it unassigned (no latch).
    always_comb begin
        vga_grant    = 1'b0;
        cpu_grant    = 1'b0;
        forced_grant = 1'b0;
        if (!reset) begin
            if (starved && bus.cpu_req) begin
                cpu_grant    = 1'b1;
                forced_grant = 1'b1;
            end else if (bus.n_blank) begin
                vga_grant = bus.vga_req;
                cpu_grant = !bus.vga_req && bus.cpu_req;
            end else begin
                cpu_grant = bus.cpu_req;
                vga_grant = !bus.cpu_req && bus.vga_req;
            end
        end
    end

    // Count consecutive denied CPU cycles, saturating; any grant or idle clears it.
    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (bus.cpu_req && !cpu_grant) begin
            if (!starved) starve_cnt <= starve_cnt + CNT_W'(1);
        end else begin
            starve_cnt <= '0;
        end
    end

    // Register the granted request onto the RAM port; address holds when idle.
    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            mem_we_q <= 1'b0;
            if (vga_grant) begin
                mem_addr_q <= bus.vga_addr;
            end else if (cpu_grant) begin
                mem_addr_q  <= bus.cpu_addr;
                mem_we_q    <= bus.cpu_we;
                mem_wdata_q <= bus.cpu_wdata;
            end
        end
    end

    // Build the tag for this cycle's grant; writes carry no tag.
    always_comb begin
        tag_in       = '0;
        tag_in.valid = vga_grant || (cpu_grant && !bus.cpu_we);
        tag_in.owner = vga_grant ? OWN_VGA : OWN_CPU;
    end

    linea_retardo_tag #(
        .DEPTH (RD_LAT + 1)
    ) u_linea_retardo_tag (
        .clock_25 (clock_25),
        .reset    (reset),
        .tag_in   (tag_in),
        .tag_out  (tag_out)
    );

    // Route returning RAM data to its owner and pulse that owner's rvalid.
    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            vga_rdata_q  <= '0;
            cpu_rdata_q  <= '0;
            vga_rvalid_q <= 1'b0;
            cpu_rvalid_q <= 1'b0;
        end else begin
            vga_rvalid_q <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            if (tag_out.valid) begin
                if (tag_out.owner == OWN_VGA) begin
                    vga_rdata_q  <= bus.mem_rdata;
                    vga_rvalid_q <= 1'b1;
                end else begin
                    cpu_rdata_q  <= bus.mem_rdata;
                    cpu_rvalid_q <= 1'b1;
                end
            end
        end
    end

`ifdef ARB_STATS_EN
    // Saturating counters of contended cycles and starvation-forced grants.
    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            stat_conflict <= '0;
            stat_forced   <= '0;
        end else begin
            if (bus.vga_req && bus.cpu_req && stat_conflict != 16'hFFFF)
                stat_conflict <= stat_conflict + 16'd1;
            if (forced_grant && stat_forced != 16'hFFFF)
                stat_forced <= stat_forced + 16'd1;
        end
    end
`endif

    assign bus.vga_ack    = vga_grant;
    assign bus.cpu_ack    = cpu_grant;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.vga_rdata  = vga_rdata_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.vga_rvalid = vga_rvalid_q;
    assign bus.cpu_rvalid = cpu_rvalid_q;

endmodule
